// File: rtl/vmop_operand_fetch_if.sv
// Operand-fetch port bundle: instruction request, VRF read ports and the
// mask-logical unit's input stream. The master side is the fetch sequencer.
interface vmop_operand_fetch_if #(
  parameter int unsigned REQ_DATA_WIDTH = 64,
  parameter int unsigned REQ_ADDR_WIDTH = 32,
  parameter int unsigned OPSEL_WIDTH    = 3,
  parameter int unsigned VL_WIDTH       = 11
);
  logic                      in_valid;
  logic                      in_ready;
  logic [4:0]                in_vs1;
  logic [4:0]                in_vs2;
  logic [4:0]                in_vd;
  logic [OPSEL_WIDTH-1:0]    in_opSel;
  logic [VL_WIDTH-1:0]       in_vl;
  logic                      rd_en;
  logic [REQ_ADDR_WIDTH-1:0] rd_addr0;
  logic [REQ_ADDR_WIDTH-1:0] rd_addr1;
  logic [REQ_DATA_WIDTH-1:0] rd_data0;
  logic [REQ_DATA_WIDTH-1:0] rd_data1;
  logic                      out_valid;
  logic [REQ_DATA_WIDTH-1:0] out_m0;
  logic [REQ_DATA_WIDTH-1:0] out_m1;
  logic [OPSEL_WIDTH-1:0]    out_opSel;
  logic [REQ_ADDR_WIDTH-1:0] out_addr;
  logic                      done;

  modport master (
    input  in_valid, in_vs1, in_vs2, in_vd, in_opSel, in_vl, rd_data0, rd_data1,
    output in_ready, rd_en, rd_addr0, rd_addr1, out_valid, out_m0, out_m1, out_opSel,
    output out_addr, done
  );

  modport slave (
    output in_valid, in_vs1, in_vs2, in_vd, in_opSel, in_vl, rd_data0, rd_data1,
    input  in_ready, rd_en, rd_addr0, rd_addr1, out_valid, out_m0, out_m1, out_opSel,
    input  out_addr, done
  );
endinterface

// File: rtl/vmop_operand_fetch.sv
// Mask-logical operand fetch: reads vs1/vs2 word by word, clears tail bits beyond vl
// and streams one operand pair per cycle into the mask-logical unit.
module vmop_operand_fetch #(
  parameter int unsigned REQ_DATA_WIDTH = 64,
  parameter int unsigned REQ_ADDR_WIDTH = 32,
  parameter int unsigned OPSEL_WIDTH    = 3,
  parameter int unsigned VLEN           = 1024,
  parameter int unsigned VL_WIDTH       = 11
) (
  input logic                  clk,
  input logic                  rst,
  vmop_operand_fetch_if.master bus
);
  localparam int unsigned REG_WORDS = VLEN / REQ_DATA_WIDTH;
  localparam int unsigned WordBits  = $clog2(REG_WORDS);
  localparam int unsigned LsbBits   = $clog2(REQ_DATA_WIDTH);

  typedef enum logic [2:0] {StInit, StIdle, StZero, StRead, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [4:0]                vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [OPSEL_WIDTH-1:0]    op_q, op_d;
  logic [LsbBits-1:0]        rem_q, rem_d;
  logic [WordBits-1:0]       last_w_q, last_w_d, w_q, w_d;
  logic                      drain_q, drain_d;
  logic                      s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [WordBits-1:0]       s1_w_q, s1_w_d;
  logic                      out_valid_q, out_valid_d;
  logic [REQ_DATA_WIDTH-1:0] out_m0_q, out_m0_d, out_m1_q, out_m1_d;
  logic [OPSEL_WIDTH-1:0]    out_op_q, out_op_d;
  logic [REQ_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;

  logic                      in_ready, rd_en, done;
  logic [VL_WIDTH-1:0]       vl_eff;
  logic [REQ_DATA_WIDTH-1:0] mask;

  always_comb begin
    state_d  = state_q;
    vs1_d    = vs1_q;
    vs2_d    = vs2_q;
    vd_d     = vd_q;
    op_d     = op_q;
    rem_d    = rem_q;
    last_w_d = last_w_q;
    w_d      = w_q;
    drain_d  = drain_q;
    in_ready = 1'b0;
    rd_en    = 1'b0;
    done     = 1'b0;
    vl_eff   = (bus.in_vl > VL_WIDTH'(VLEN)) ? VL_WIDTH'(VLEN) : bus.in_vl;

    unique case (state_q)
      StInit: state_d = StIdle;
      StIdle: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          vs1_d    = bus.in_vs1;
          vs2_d    = bus.in_vs2;
          vd_d     = bus.in_vd;
          op_d     = bus.in_opSel;
          rem_d    = vl_eff[LsbBits-1:0];
          // Index of the final word, i.e. ceil(vl_eff / width) - 1.
          last_w_d = WordBits'((vl_eff - VL_WIDTH'(1)) >> LsbBits);
          w_d      = '0;
          state_d  = (vl_eff == '0) ? StZero : StRead;
        end
      end
      StZero: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      StRead: begin
        rd_en = 1'b1;
        w_d   = w_q + WordBits'(1);
        if (w_q == last_w_q) begin
          drain_d = 1'b0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        drain_d = 1'b1;
        if (drain_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Two-stage return path: stage 1 tags the read in flight, stage 2 masks and registers.
  always_comb begin
    s1_valid_d = rd_en;
    s1_last_d  = rd_en && (w_q == last_w_q);
    s1_w_d     = w_q;
    mask       = '1;
    if (s1_last_q && (rem_q != '0)) begin
      mask = ~({REQ_DATA_WIDTH{1'b1}} << rem_q);
    end
    out_valid_d = s1_valid_q;
    out_m0_d    = '0;
    out_m1_d    = '0;
    out_op_d    = '0;
    out_addr_d  = '0;
    if (s1_valid_q) begin
      out_m0_d   = bus.rd_data0 & mask;
      out_m1_d   = bus.rd_data1 & mask;
      out_op_d   = op_q;
      out_addr_d = REQ_ADDR_WIDTH'({vd_q, s1_w_q});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      vs1_q       <= '0;
      vs2_q       <= '0;
      vd_q        <= '0;
      op_q        <= '0;
      rem_q       <= '0;
      last_w_q    <= '0;
      w_q         <= '0;
      drain_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_w_q      <= '0;
      out_valid_q <= 1'b0;
      out_m0_q    <= '0;
      out_m1_q    <= '0;
      out_op_q    <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      vs1_q       <= vs1_d;
      vs2_q       <= vs2_d;
      vd_q        <= vd_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      last_w_q    <= last_w_d;
      w_q         <= w_d;
      drain_q     <= drain_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_w_q      <= s1_w_d;
      out_valid_q <= out_valid_d;
      out_m0_q    <= out_m0_d;
      out_m1_q    <= out_m1_d;
      out_op_q    <= out_op_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr0  = rd_en ? REQ_ADDR_WIDTH'({vs1_q, w_q}) : '0;
  assign bus.rd_addr1  = rd_en ? REQ_ADDR_WIDTH'({vs2_q, w_q}) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_m0    = out_m0_q;
  assign bus.out_m1    = out_m1_q;
  assign bus.out_opSel = out_op_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.done      = done;
endmodule

// File: tb/tb_vmop_operand_fetch.sv
// Randomized bench for vmop_operand_fetch: a VRF array model answers reads and a
// cycle-indexed reference derives every expected output from vl, register indices and timing.
module tb_vmop_operand_fetch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vmop_operand_fetch_if bus ();

  vmop_operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] mem [512];
  int n_cmp = 0;
  int n_err = 0;
  int last_wait;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data0 <= mem[bus.rd_addr0[8:0]];
      bus.rd_data1 <= mem[bus.rd_addr1[8:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit b of word k survives only if its element index k*64+b is below vl.
  function automatic logic [63:0] ref_word(input logic [63:0] d, input int k, input int vle);
    logic [63:0] r;
    r = d;
    for (int b = 0; b < 64; b++) if (k * 64 + b >= vle) r[b] = 1'b0;
    return r;
  endfunction

  task automatic fill_mem(input bit ones);
    for (int i = 0; i < 512; i++) mem[i] = ones ? '1 : {$urandom, $urandom};
  endtask

  // Called at a negedge; issues one instruction and checks every cycle until in_ready returns.
  task automatic run(input int vs1, input int vs2, input int vd, input int op, input int vl,
                     input bit hold, input int abort_at);
    int vle, n, done_c, ready_c, k;
    logic [63:0] e0, e1, ea, eo;
    bit ov;
    vle     = (vl > 1024) ? 1024 : vl;
    n       = (vle + 63) / 64;
    done_c  = (n == 0) ? 1 : n + 2;
    ready_c = done_c + 1;
    bus.in_vs1   = vs1[4:0];
    bus.in_vs2   = vs2[4:0];
    bus.in_vd    = vd[4:0];
    bus.in_opSel = op[2:0];
    bus.in_vl    = vl[10:0];
    bus.in_valid = 1'b1;
    last_wait = 0;
    while (!bus.in_ready && last_wait < 50) begin
      @(negedge clk);
      last_wait++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= ready_c; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) bus.in_valid = 1'b0;
      if (c == abort_at) return;
      check("rd_en", 64'(bus.rd_en), 64'(c <= n));
      if (c <= n) begin
        check("rd_addr0", 64'(bus.rd_addr0), 64'(vs1 * 16 + c - 1));
        check("rd_addr1", 64'(bus.rd_addr1), 64'(vs2 * 16 + c - 1));
      end
      ov = (c >= 3) && (c <= n + 2);
      k  = c - 3;
      e0 = '0; e1 = '0; ea = '0; eo = '0;
      if (ov) begin
        e0 = ref_word(mem[vs1 * 16 + k], k, vle);
        e1 = ref_word(mem[vs2 * 16 + k], k, vle);
        ea = 64'(vd * 16 + k);
        eo = 64'(op);
      end
      check("out_valid", 64'(bus.out_valid), 64'(ov));
      check("out_m0", bus.out_m0, e0);
      check("out_m1", bus.out_m1, e1);
      check("out_addr", 64'(bus.out_addr), ea);
      check("out_opSel", 64'(bus.out_opSel), eo);
      check("done", 64'(bus.done), 64'(c == done_c));
      check("in_ready", 64'(bus.in_ready), 64'(c == ready_c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int vl, sel;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vs1 = '0; bus.in_vs2 = '0; bus.in_vd = '0; bus.in_opSel = '0; bus.in_vl = '0;
    fill_mem(1'b0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_rd_en", 64'(bus.rd_en), 64'd0);
    check("rst_rd_addr0", 64'(bus.rd_addr0), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_m0", bus.out_m0, 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);

    run(1, 2, 3, 0, 64, 1'b0, 0);
    fill_mem(1'b1);
    run(5, 6, 7, 3, 200, 1'b0, 0);
    fill_mem(1'b0);
    run(4, 9, 2, 5, 0, 1'b0, 0);
    run(10, 11, 31, 7, 2000, 1'b0, 0);

    run(3, 4, 5, 1, 150, 1'b1, 0);
    run(7, 8, 9, 2, 100, 1'b0, 0);
    check("hold_accept_wait", 64'(last_wait), 64'd0);

    run(12, 13, 14, 6, 512, 1'b0, 2);
    rst = 1'b0;
    #1;
    check("arst_rd_en", 64'(bus.rd_en), 64'd0);
    check("arst_rd_addr0", 64'(bus.rd_addr0), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd0);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    repeat (2) begin
      @(negedge clk);
      check("arst_hold_done", 64'(bus.done), 64'd0);
      check("arst_hold_out_valid", 64'(bus.out_valid), 64'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rerst_ready", 64'(bus.in_ready), 64'd1);
    run(15, 16, 17, 4, 330, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      fill_mem(1'b0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       vl = $urandom_range(0, 2047);
        1:       vl = 64 * $urandom_range(0, 16);
        2:       vl = $urandom_range(1, 1100);
        default: vl = $urandom_range(1025, 2047);
      endcase
      run($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 7), vl, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vmop_operand_fetch.md
# vmop_operand_fetch

Upstream sequencer for the vector mask-logical unit (vmand/vmnand/vmandn/vmxor/vmor/vmorn/vmnor/vmxnor). It accepts one mask-logical instruction, reads the two source mask registers word by word from the vector register file, and zeroes tail bits beyond vl. It then streams the operand pairs, opcode and destination word address into the mask-logical unit's input port (in_m0/in_m1/in_opSel/in_addr/in_valid). The mask-logical unit has no backpressure, so this block issues one word per cycle, without stalls, once reads begin.

## Interface
- REQ_DATA_WIDTH, 64: VRF word width and operand width.
- REQ_ADDR_WIDTH, 32: VRF word address width.
- OPSEL_WIDTH, 3: opcode width, passed through unchanged.
- VLEN, 1024: bits per vector register; REG_WORDS = VLEN/REQ_DATA_WIDTH (16); both are powers of two.
- VL_WIDTH, 11: width of in_vl (covers 0..VLEN).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  instruction request.
- in_ready  out  1  high only in IDLE; accept = in_valid & in_ready.
- in_vs1, in_vs2, in_vd  in  5 each  source-1, source-2, destination register index.
- in_opSel  in  OPSEL_WIDTH  mask-logical opcode.
- in_vl  in  VL_WIDTH  element (bit) count.
- rd_en  out  1  VRF read strobe for both read ports.
- rd_addr0, rd_addr1  out  REQ_ADDR_WIDTH  word addresses for vs1 and vs2.
- rd_data0, rd_data1  in  REQ_DATA_WIDTH  read data, valid exactly 1 cycle after rd_en.
- out_valid  out  1  drives the unit's in_valid.
- out_m0, out_m1  out  REQ_DATA_WIDTH  operands; m0 comes from vs1, m1 from vs2.
- out_opSel  out  OPSEL_WIDTH  opcode.
- out_addr  out  REQ_ADDR_WIDTH  destination word address.
- done  out  1  one-cycle pulse when the instruction completes.

## Operation
- On accept, latch vs1, vs2, vd and opSel, and the effective vl: vl_eff = min(in_vl, VLEN).
- Word count: nwords = ceil(vl_eff/REQ_DATA_WIDTH).
- Address of word w of register r is r*REG_WORDS + w, zero-extended to REQ_ADDR_WIDTH.
  - rd_addr0 uses vs1; rd_addr1 uses vs2; out_addr uses vd.
- FSM states:
  - IDLE: in_ready = 1. On accept with vl_eff > 0, go to READ with word counter w = 0. On accept with vl_eff = 0, go to ZERO.
  - ZERO: no reads and no out_valid; done = 1 for one cycle; then return to IDLE.
  - READ: rd_en = 1 with addresses for w, then w increments. After issuing w = nwords-1, go to DRAIN.
  - DRAIN: lasts 2 cycles while the final data returns and is output, then return to IDLE.
- Output register: loaded 1 cycle after the rd_data cycle. out_valid is rd_en delayed by 2 cycles.
  - out_m0 and out_m1 are rd_data0 and rd_data1 with bit positions ≥ vl_eff mod REQ_DATA_WIDTH cleared.
  - Clearing applies only to the last word, and only when that remainder is nonzero.
  - out_addr is the matching vd word address; out_opSel is the latched opcode.
- done is asserted in the same cycle as the last out_valid.
- When out_valid = 0, out_m0, out_m1, out_opSel and out_addr are all driven to 0.
- in_valid outside IDLE is ignored; no request is queued.
- rst asserted in any state forces IDLE immediately and clears all registers; the in-flight instruction is dropped with no done.

## Timing
- Reset values: in_ready 0, rd_en 0, rd_addr0/1 0, out_valid 0, out_m0/m1/opSel/addr 0, done 0.
  - in_ready goes to 1 on the first clock edge after rst deasserts.
- Accept in cycle 0 with n = nwords:
  - rd_en in cycles 1..n.
  - rd_data in cycles 2..n+1.
  - out_valid in cycles 3..n+2, contiguous with no bubbles.
  - done in cycle n+2.
  - in_ready = 0 in cycles 1..n+2 and 1 in cycle n+3.
- Latency from accept to first out_valid: 3 cycles. Throughput: 1 word/cycle; minimum instruction spacing is n+3 cycles.
- vl_eff = 0, accepted in cycle 0: done in cycle 1, in_ready = 0 in cycle 1, in_ready = 1 in cycle 2.

## Test plan
- vl=64, vs1=1, vs2=2, vd=3, opSel=0, accept in cycle 0:
  - rd_en in cycle 1 only, with rd_addr0=16 and rd_addr1=32.
  - out_valid in cycle 3 with out_addr=48 and unmasked data.
  - done in cycle 3; in_ready = 1 in cycle 4.
- vl=200, rd_data all-ones:
  - 4 reads, rd_addr0 = vs1*16+0..3.
  - out_valid in cycles 3..6; words 0..2 = all-ones, word 3 = 64'h00000000000000FF.
  - done in cycle 6.
- vl=0: no rd_en and no out_valid; done in cycle 1; in_ready high again in cycle 2.
- vl=2000 (above VLEN): clamped to 1024, giving 16 reads; last word unmasked; out_addr covers vd*16..vd*16+15.
- in_valid held high throughout a 3-word instruction: the second instruction is accepted only in cycle 6, and its first rd_en is in cycle 7.
- rst pulsed low during cycle 2 of an 8-word instruction:
  - All outputs are 0 asynchronously; no done.
  - After release, in_ready = 1 on the next edge and a fresh instruction runs correctly.
